// File: rtl/fir_controller.sv
// rtl/fir_controller.sv - Moore sequencer for the 4-tap FIR datapath
// Loads coefficients, then shifts/multiplies/accumulates one datapath op per cycle.
module fir_controller #(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dr,
  input  logic              lc,
  input  logic              overflow,
  output logic              cnt_up,
  output logic              clear,
  output logic              modwait,
  output logic [2:0]        op,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] src2,
  output logic [REG_AW-1:0] dest,
  output logic              err
);

  typedef enum logic [4:0] {
    IDLE, LOADC, WAITC, STORE, SH3, SH2, SH1, SHIN, ZERO,
    MUL0, ACC0, MUL1, ACC1, MUL2, ACC2, MUL3, ACC3, EIDLE
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_COPY  = 3'd1;
  localparam logic [2:0] OP_LOAD1 = 3'd2;
  localparam logic [2:0] OP_LOAD2 = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;

  state_t              state;
  state_t              state_n;
  logic [1:0]          idx;
  logic [2:0]          op_n;
  logic [REG_AW-1:0]   src1_n;
  logic [REG_AW-1:0]   src2_n;
  logic [REG_AW-1:0]   dest_n;
  logic                cnt_up_n;
  logic                clear_n;
  logic                modwait_n;
  logic                err_n;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, EIDLE: begin
        if (lc)      state_n = LOADC;
        else if (dr) state_n = STORE;
      end
      LOADC: state_n = WAITC;
      WAITC: begin
        if (lc)             state_n = LOADC;
        else if (idx == 2'd0) state_n = IDLE;
      end
      STORE: state_n = dr ? SH3 : EIDLE;
      SH3:   state_n = SH2;
      SH2:   state_n = SH1;
      SH1:   state_n = SHIN;
      SHIN:  state_n = ZERO;
      ZERO:  state_n = MUL0;
      MUL0:  state_n = ACC0;
      ACC0:  state_n = overflow ? EIDLE : MUL1;
      MUL1:  state_n = ACC1;
      ACC1:  state_n = overflow ? EIDLE : MUL2;
      MUL2:  state_n = ACC2;
      ACC2:  state_n = overflow ? EIDLE : MUL3;
      MUL3:  state_n = ACC3;
      ACC3:  state_n = overflow ? EIDLE : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they are registered alongside it.
  always_comb begin
    op_n      = OP_NOP;
    src1_n    = '0;
    src2_n    = '0;
    dest_n    = '0;
    cnt_up_n  = 1'b0;
    clear_n   = 1'b0;
    modwait_n = 1'b0;
    err_n     = 1'b0;
    unique case (state_n)
      LOADC: begin
        op_n      = OP_LOAD2;
        dest_n    = REG_AW'(5) + REG_AW'(idx);
        clear_n   = (idx == 2'd0);
        modwait_n = 1'b1;
      end
      STORE: begin op_n = OP_LOAD1; dest_n = REG_AW'(10); modwait_n = 1'b1; end
      SH3:   begin op_n = OP_COPY; src1_n = REG_AW'(3);  dest_n = REG_AW'(4); modwait_n = 1'b1; end
      SH2:   begin op_n = OP_COPY; src1_n = REG_AW'(2);  dest_n = REG_AW'(3); modwait_n = 1'b1; end
      SH1:   begin op_n = OP_COPY; src1_n = REG_AW'(1);  dest_n = REG_AW'(2); modwait_n = 1'b1; end
      SHIN:  begin op_n = OP_COPY; src1_n = REG_AW'(10); dest_n = REG_AW'(1); modwait_n = 1'b1; end
      ZERO:  begin op_n = OP_SUB; cnt_up_n = 1'b1; modwait_n = 1'b1; end
      MUL0:  begin op_n = OP_MUL; src1_n = REG_AW'(1); src2_n = REG_AW'(5); dest_n = REG_AW'(9); modwait_n = 1'b1; end
      MUL1:  begin op_n = OP_MUL; src1_n = REG_AW'(2); src2_n = REG_AW'(6); dest_n = REG_AW'(9); modwait_n = 1'b1; end
      MUL2:  begin op_n = OP_MUL; src1_n = REG_AW'(3); src2_n = REG_AW'(7); dest_n = REG_AW'(9); modwait_n = 1'b1; end
      MUL3:  begin op_n = OP_MUL; src1_n = REG_AW'(4); src2_n = REG_AW'(8); dest_n = REG_AW'(9); modwait_n = 1'b1; end
      ACC0, ACC2: begin op_n = OP_ADD; src2_n = REG_AW'(9); modwait_n = 1'b1; end
      ACC1, ACC3: begin op_n = OP_SUB; src2_n = REG_AW'(9); modwait_n = 1'b1; end
      EIDLE: err_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 2'd0;
      op      <= OP_NOP;
      src1    <= '0;
      src2    <= '0;
      dest    <= '0;
      cnt_up  <= 1'b0;
      clear   <= 1'b0;
      modwait <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      if (state == LOADC) idx <= idx + 2'd1;
      op      <= op_n;
      src1    <= src1_n;
      src2    <= src2_n;
      dest    <= dest_n;
      cnt_up  <= cnt_up_n;
      clear   <= clear_n;
      modwait <= modwait_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_fir_controller.sv
// tb/tb_fir_controller.sv - scoreboard bench for fir_controller
module tb_fir_controller;

  logic       clk = 1'b0;
  logic       rst, dr, lc, ov;
  logic       cnt_up, clear, modwait, err;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;

  int total = 0;
  int bad   = 0;

  logic [3:0]  stim_q[$];
  logic [18:0] exp_q[$];
  logic [18:0] e;
  wire  [18:0] obs = {err, modwait, clear, cnt_up, op, src1, src2, dest};

  fir_controller #(.REG_AW(4)) dut (
    .clk(clk), .rst(rst), .dr(dr), .lc(lc), .overflow(ov),
    .cnt_up(cnt_up), .clear(clear), .modwait(modwait), .op(op),
    .src1(src1), .src2(src2), .dest(dest), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input int o, input int s1, input int s2, input int d,
                                     input logic cu, input logic cl, input logic mw, input logic er);
    return {er, mw, cl, cu, 3'(o), 4'(s1), 4'(s2), 4'(d)};
  endfunction

  // Expected op/src/dest for STORE..ACC3 of a sample run.
  function automatic logic [18:0] run_exp(input int i);
    case (i)
      0:  return mk(2, 0, 0, 10, 0, 0, 1, 0);
      1:  return mk(1, 3, 0, 4, 0, 0, 1, 0);
      2:  return mk(1, 2, 0, 3, 0, 0, 1, 0);
      3:  return mk(1, 1, 0, 2, 0, 0, 1, 0);
      4:  return mk(1, 10, 0, 1, 0, 0, 1, 0);
      5:  return mk(5, 0, 0, 0, 1, 0, 1, 0);
      6:  return mk(6, 1, 5, 9, 0, 0, 1, 0);
      7:  return mk(4, 0, 9, 0, 0, 0, 1, 0);
      8:  return mk(6, 2, 6, 9, 0, 0, 1, 0);
      9:  return mk(5, 0, 9, 0, 0, 0, 1, 0);
      10: return mk(6, 3, 7, 9, 0, 0, 1, 0);
      11: return mk(4, 0, 9, 0, 0, 0, 1, 0);
      12: return mk(6, 4, 8, 9, 0, 0, 1, 0);
      default: return mk(5, 0, 9, 0, 0, 0, 1, 0);
    endcase
  endfunction

  localparam logic [18:0] IDLE_O  = 19'h0;
  localparam logic [18:0] EIDLE_O = 19'h40000;

  // stim bits: {rst, dr, lc, overflow}
  task automatic test_reset();
    int n = 0;
    stim_q.push_back(4'b1110); exp_q.push_back(IDLE_O);
    stim_q.push_back(4'b1110); exp_q.push_back(IDLE_O);
    stim_q.push_back(4'b0110); exp_q.push_back(mk(3, 0, 0, 5, 0, 1, 1, 0));
    stim_q.push_back(4'b0000); exp_q.push_back(IDLE_O);
    stim_q.push_back(4'b1000); exp_q.push_back(IDLE_O);
    while (stim_q.size() > 0) begin
      {rst, dr, lc, ov} = stim_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", n, obs, e); end
      n++;
    end
  endtask

  task automatic test_coeff_load();
    int n = 0;
    for (int k = 0; k < 4; k++) begin
      stim_q.push_back(4'b0010); exp_q.push_back(mk(3, 0, 0, 5 + k, 0, k == 0, 1, 0));
      for (int j = 0; j < 3; j++) begin
        // dr while waiting for the next coefficient must be dropped
        stim_q.push_back((k == 0 && j == 1) ? 4'b0100 : 4'b0000);
        exp_q.push_back(IDLE_O);
      end
    end
    while (stim_q.size() > 0) begin
      {rst, dr, lc, ov} = stim_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL coeff_load cyc=%0d got=%h exp=%h", n, obs, e); end
      n++;
    end
  endtask

  task automatic test_sample_run();
    int n = 0;
    for (int i = 0; i < 14; i++) begin
      stim_q.push_back(i < 2 ? 4'b0100 : 4'b0000); exp_q.push_back(run_exp(i));
    end
    stim_q.push_back(4'b0000); exp_q.push_back(IDLE_O);
    stim_q.push_back(4'b0000); exp_q.push_back(IDLE_O);
    while (stim_q.size() > 0) begin
      {rst, dr, lc, ov} = stim_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL sample_run cyc=%0d got=%h exp=%h", n, obs, e); end
      n++;
    end
  endtask

  task automatic test_lost_sample();
    int n = 0;
    stim_q.push_back(4'b0100); exp_q.push_back(run_exp(0));
    stim_q.push_back(4'b0000); exp_q.push_back(EIDLE_O);
    stim_q.push_back(4'b0000); exp_q.push_back(EIDLE_O);
    for (int i = 0; i < 14; i++) begin
      stim_q.push_back(i < 2 ? 4'b0100 : 4'b0000); exp_q.push_back(run_exp(i));
    end
    stim_q.push_back(4'b0000); exp_q.push_back(IDLE_O);
    while (stim_q.size() > 0) begin
      {rst, dr, lc, ov} = stim_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL lost_sample cyc=%0d got=%h exp=%h", n, obs, e); end
      n++;
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    // overflow during MUL2 is ignored; during ACC2 it diverts to EIDLE
    for (int i = 0; i < 13; i++) begin
      stim_q.push_back({1'b0, i < 2, 1'b0, i >= 11});
      exp_q.push_back(i < 12 ? run_exp(i) : EIDLE_O);
    end
    stim_q.push_back(4'b0000); exp_q.push_back(EIDLE_O);
    stim_q.push_back(4'b0000); exp_q.push_back(EIDLE_O);
    while (stim_q.size() > 0) begin
      {rst, dr, lc, ov} = stim_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL overflow cyc=%0d got=%h exp=%h", n, obs, e); end
      n++;
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    for (int i = 0; i < 9; i++) begin
      stim_q.push_back(i < 2 ? 4'b0100 : 4'b0000); exp_q.push_back(run_exp(i));
    end
    stim_q.push_back(4'b1000); exp_q.push_back(IDLE_O);
    stim_q.push_back(4'b0000); exp_q.push_back(IDLE_O);
    stim_q.push_back(4'b0010); exp_q.push_back(mk(3, 0, 0, 5, 0, 1, 1, 0));
    stim_q.push_back(4'b0000); exp_q.push_back(IDLE_O);
    stim_q.push_back(4'b0010); exp_q.push_back(mk(3, 0, 0, 6, 0, 0, 1, 0));
    stim_q.push_back(4'b1010); exp_q.push_back(IDLE_O);
    stim_q.push_back(4'b0010); exp_q.push_back(mk(3, 0, 0, 5, 0, 1, 1, 0));
    stim_q.push_back(4'b0000); exp_q.push_back(IDLE_O);
    while (stim_q.size() > 0) begin
      {rst, dr, lc, ov} = stim_q.pop_front();
      @(posedge clk); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL mid_reset cyc=%0d got=%h exp=%h", n, obs, e); end
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; dr = 1'b0; lc = 1'b0; ov = 1'b0;
    test_reset();
    test_coeff_load();
    test_sample_run();
    test_lost_sample();
    test_overflow();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_controller.md
Name: fir_controller

Overview:
- Moore FSM that sequences the 4-tap FIR datapath: register file, ALU (add/sub/mul) and the 17-bit signed-to-16-bit magnitude stage on R0.
- Issues one datapath op per cycle.
- Loads four coefficients on request, and runs a shift/multiply/accumulate sequence per input sample.
- Flags ALU overflow or a lost sample as an error to the host-side wrapper.

Parameters:
REG_AW, 4, register-file address width (16 registers; map below is fixed for this width)

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
dr  in  1  data ready: new sample available on datapath load bus
lc  in  1  load coefficient: new coefficient available on load bus
overflow  in  1  ALU overflow, combinational from datapath for the op currently presented
cnt_up  out  1  one-cycle pulse per processed sample (sample counter)
clear  out  1  one-cycle pulse clearing sample counter at start of coefficient set
modwait  out  1  busy; host must not present new dr/lc while high
op  out  3  0 NOP, 1 COPY, 2 LOAD1 (sample bus), 3 LOAD2 (coeff bus), 4 ADD, 5 SUB, 6 MUL
src1  out  REG_AW  ALU source 1 address
src2  out  REG_AW  ALU source 2 address
dest  out  REG_AW  destination address
err  out  1  error flag, high while in EIDLE

Behaviour:
- Reset and clocking:
  - One clock, clk.
  - Reset is synchronous and active-high: rst sampled high at a rising edge forces state IDLE and coefficient index 0.
  - rst overrides all other inputs and aborts any sequence mid-operation.
- Output timing: all outputs are registered/decoded from current state only (Moore).
- Default outputs: NOP, addresses 0, strobes 0, modwait 0, err 0.
- Register map:
  - R0 accumulator (feeds magnitude).
  - R1..R4 sample delay line, R1 newest.
  - R5..R8 coefficients F0..F3.
  - R9 product temp.
  - R10 incoming sample temp.
- States and outputs:
  - IDLE: defaults. lc=1 -> LOADC; else dr=1 -> STORE. lc has priority when both are high.
  - LOADC: op LOAD2, dest R(5+idx), modwait 1, clear=1 iff idx==0. Next WAITC; idx increments, wrapping 3->0.
  - WAITC: defaults. lc=1 -> LOADC. Else, if idx==0 (set complete) -> IDLE; otherwise stay.
  - STORE: op LOAD1, dest R10, modwait 1. dr=0 in this cycle -> EIDLE (sample lost); else -> SH3.
  - SH3: COPY R4<-R3. SH2: COPY R3<-R2. SH1: COPY R2<-R1. SHIN: COPY R1<-R10.
  - ZERO: SUB R0<-R0-R0, cnt_up=1.
  - MULk (k=0..3): MUL R9<-R(1+k)*R(5+k).
  - ACCk: ADD R0<-R0+R9 for k even; SUB R0<-R0-R9 for k odd.
  - After ACC3 -> IDLE.
  - modwait is 1 in STORE through ACC3.
  - For COPY, src1 carries the source address and src2 is 0.
- Overflow:
  - Sampled only in ACCk states.
  - overflow=1 -> EIDLE instead of the next state.
  - The op in that cycle is still issued.
- EIDLE: defaults except err=1. Same transitions as IDLE (lc -> LOADC, dr -> STORE); err drops on leaving.
- Latency: dr seen in IDLE -> 14 cycles with modwait=1 (STORE..ACC3) -> IDLE. R0 holds the result from the cycle after ACC3.
- Input handling during busy states:
  - dr/lc in any busy state other than STORE are ignored (not queued).
  - dr during WAITC is ignored.

Test Plan:
- Reset: rst=1 for 2 cycles with dr=lc=1 -> state IDLE, op=0, modwait=0, err=0, cnt_up=0; release -> LOADC next cycle (lc priority).
- Coefficient load: four lc pulses separated by 3 idle cycles -> LOAD2 with dest 5,6,7,8 in order, clear=1 only on the first, modwait=1 only in LOADC cycles; IDLE after the fourth.
- Sample run: dr held 2 cycles from IDLE -> exact op/src/dest sequence STORE..ACC3 (14 cycles), cnt_up single pulse in cycle 6, ACC1/ACC3 op=5, ACC0/ACC2 op=4, back to IDLE.
- Lost sample: dr 1-cycle pulse dropping before STORE -> EIDLE, err=1; subsequent dr held 2 cycles -> full run, err=0 from STORE onward.
- Overflow: force overflow=1 during ACC2 -> ADD still issued that cycle, next state EIDLE, err=1, modwait=0; MUL3/ACC3 never issued.
- Mid-run reset: rst=1 during MUL1 -> next cycle IDLE with all outputs default; idx reset (next lc writes dest R5).
